shift595_rx: RTL and testbench



---
 rtl/shift595_rx.sv | 142 ++++++++++++++
 tb/tb_shift595_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift595_rx.sv
// 74HC595-style serial link receiver: synchronises SCLK/RCLK/DIO, shifts DIO MSB-first and latches on RCLK.
// Optional glitch filter on the synchronised inputs is enabled with `define SHIFT595_RX_FILTER_EN.
`timescale 1ns/1ps
module shift595_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             SCLK,
    input  logic             RCLK,
    input  logic             DIO,
    output logic [WIDTH-1:0] data595,
    output logic             data_vld,
    output logic             frame_err,
    output logic [7:0]       frame_cnt,
    output logic             Q7S
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    // Bit order in all 3-bit input vectors: [2]=SCLK, [1]=RCLK, [0]=DIO.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  sync_lvl;
    logic [2:0]                  filt_lvl;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {SCLK, RCLK, DIO}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef SHIFT595_RX_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_filt
            logic           filt_q, filt_d;
            logic [FCW-1:0] fcnt_q, fcnt_d;

            // Level only follows the input after FILT_LEN consecutive differing samples.
            always_comb begin
                filt_d = filt_q;
                fcnt_d = fcnt_q;
                if (sync_lvl[gi] == filt_q) begin
                    fcnt_d = '0;
                end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
                    filt_d = sync_lvl[gi];
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    filt_q <= 1'b0;
                    fcnt_q <= '0;
                end else begin
                    filt_q <= filt_d;
                    fcnt_q <= fcnt_d;
                end
            end

            assign filt_lvl[gi] = filt_q;
        end
    endgenerate
`else
    assign filt_lvl = sync_lvl;
`endif

    logic [1:0] prev_q;
    logic       sclk_rise, rclk_rise, dio_lvl;

    assign sclk_rise = filt_lvl[2] & ~prev_q[1];
    assign rclk_rise = filt_lvl[1] & ~prev_q[0];
    assign dio_lvl   = filt_lvl[0];

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    always_comb begin
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        data_d      = data_q;
        vld_d       = 1'b0;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        if (sclk_rise) begin
            shift_d = {shift_q[WIDTH-2:0], dio_lvl};
            if (bitcnt_q != CNT_MAX) bitcnt_d = bitcnt_q + 1'b1;
        end
        // A latch always captures the pre-shift word; a coincident shift counts as bit 1 of the next frame.
        if (rclk_rise) begin
            data_d      = shift_q;
            vld_d       = 1'b1;
            err_d       = (bitcnt_q != CNT_FULL);
            frame_cnt_d = frame_cnt_q + 8'd1;
            bitcnt_d    = sclk_rise ? CW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q      <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            prev_q      <= filt_lvl[2:1];
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign data595   = data_q;
    assign data_vld  = vld_q;
    assign frame_err = err_q;
    assign frame_cnt = frame_cnt_q;
    assign Q7S       = shift_q[WIDTH-1];

endmodule

// File: tb/tb_shift595_rx.sv
// Self-checking bench for shift595_rx: vector table, hand-written corner sequences and random frames vs a word-level model.
`timescale 1ns/1ps
module tb_shift595_rx;

`ifdef SHIFT595_RX_FILTER_EN
    localparam int FAST_H = 3;
    localparam int SLOW_H = 4;
`else
    localparam int FAST_H = 1;
    localparam int SLOW_H = 2;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        SCLK = 1'b0, RCLK = 1'b0, DIO = 1'b0;
    logic [15:0] data595;
    logic        data_vld, frame_err, Q7S;
    logic [7:0]  frame_cnt;

    shift595_rx #(.WIDTH(16), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk(clk), .rstn(rstn), .SCLK(SCLK), .RCLK(RCLK), .DIO(DIO),
        .data595(data595), .data_vld(data_vld), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .Q7S(Q7S)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int vld_seen = 0;

    // Word-level model: last 16 bits shifted, shifts since last latch, latch count.
    logic [15:0] m_sr;
    int          m_cnt;
    logic [7:0]  m_fc;
    int          m_latches = 0;

    always @(negedge clk) if (data_vld) vld_seen++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_sr  = '0;
        m_cnt = 0;
        m_fc  = '0;
    endtask

    task automatic model_shift(input logic b);
        m_sr = 16'(({16'h0, m_sr} << 1) | 32'(b));
        if (m_cnt < 31) m_cnt++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        SCLK = 1'b0; RCLK = 1'b0; DIO = 1'b0;
        wait_cyc(3);
        check("reset_outputs", {data595, data_vld, frame_err, frame_cnt, Q7S}, 32'h0);
        rstn = 1'b1;
        wait_cyc(2);
        model_reset();
        $display("reset applied");
    endtask

    task automatic send_bit(input logic b, input int h);
        SCLK = 1'b0;
        DIO  = b;
        wait_cyc(h);
        SCLK = 1'b1;
        wait_cyc(h);
        model_shift(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input int h);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], h);
        SCLK = 1'b0;
        wait_cyc(h);
    endtask

    // Raise RCLK, wait for the data_vld pulse and compare against the given expectation.
    task automatic latch_chk(input logic [15:0] ed, input logic ee, input int h, input string tag);
        bit got;
        wait_cyc(8);
        check({tag, "_q7s"}, Q7S, ed[15]);
        RCLK = 1'b1;
        m_cnt = 0;
        m_fc  = m_fc + 8'd1;
        m_latches++;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (data_vld) begin
                got = 1;
                break;
            end
        end
        check({tag, "_vld_seen"}, got, 1);
        if (got) begin
            check({tag, "_data"}, data595, ed);
            check({tag, "_err"}, frame_err, ee);
            check({tag, "_fcnt"}, frame_cnt, m_fc);
            @(negedge clk);
            check({tag, "_vld_1cyc"}, data_vld, 0);
        end
        $display("latch %s: data595=0x%04h frame_err=%0b frame_cnt=%0d (exp 0x%04h/%0b)",
                 tag, data595, frame_err, frame_cnt, ed, ee);
        RCLK = 1'b0;
        wait_cyc(h);
    endtask

    typedef struct {
        bit          rst;
        int          nbits;
        logic [31:0] word;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 16, 32'h0000A5C3, 16'hA5C3, 1'b0};
        vt[1] = '{1'b1, 12, 32'h00000FFF, 16'h0FFF, 1'b1};
        vt[2] = '{1'b0, 20, 32'h00012345, 16'h2345, 1'b1};
        vt[3] = '{1'b0,  0, 32'h00000000, 16'h2345, 1'b1};
        vt[4] = '{1'b0, 16, 32'h00000000, 16'h0000, 1'b0};
        vt[5] = '{1'b0, 16, 32'h0000FFFF, 16'hFFFF, 1'b0};
        vt[6] = '{1'b0, 17, 32'h00018001, 16'h8001, 1'b1};
        vt[7] = '{1'b1,  0, 32'h00000000, 16'h0000, 1'b1};
        vt[8] = '{1'b0, 32, 32'hDEADBEEF, 16'hBEEF, 1'b1};

        model_reset();
        do_reset();

        // Idle: nothing may move while all inputs stay low.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle", {data595, data_vld, frame_err, frame_cnt, Q7S}, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            if (vt[i].rst) do_reset();
            send_word(vt[i].word, vt[i].nbits, SLOW_H);
            latch_chk(vt[i].exp_data, vt[i].exp_err, SLOW_H, $sformatf("vec%0d", i));
        end

        // Coincident SCLK and RCLK rise: latch sees 0xFFFF, then 15 more bits complete a good frame.
        do_reset();
        send_word(32'hFFFF, 16, SLOW_H);
        DIO = 1'b0;
        wait_cyc(SLOW_H);
        begin
            bit got;
            SCLK = 1'b1;
            RCLK = 1'b1;
            m_fc = m_fc + 8'd1;
            m_latches++;
            got = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (data_vld) begin
                    got = 1;
                    break;
                end
            end
            check("simul_vld_seen", got, 1);
            check("simul_data", data595, 16'hFFFF);
            check("simul_err", frame_err, 0);
            check("simul_fcnt", frame_cnt, m_fc);
            $display("latch simul: data595=0x%04h frame_err=%0b", data595, frame_err);
            m_cnt = 0;
            model_shift(1'b0);
            wait_cyc(SLOW_H);
            SCLK = 1'b0;
            RCLK = 1'b0;
            wait_cyc(SLOW_H);
        end
        send_word(32'h5A5A, 15, SLOW_H);
        latch_chk(m_sr, 1'b0, SLOW_H, "simul_next");

        // Reset in the middle of a frame discards the partial word.
        do_reset();
        for (int i = 0; i < 8; i++) send_bit(1'b1, SLOW_H);
        #2;
        do_reset();
        send_word(32'h8001, 16, SLOW_H);
        latch_chk(16'h8001, 1'b0, SLOW_H, "midreset");
        check("midreset_fcnt1", frame_cnt, 1);

`ifdef SHIFT595_RX_FILTER_EN
        // A single-cycle SCLK glitch must not shift.
        do_reset();
        DIO = 1'b1;
        wait_cyc(SLOW_H);
        SCLK = 1'b1;
        wait_cyc(1);
        SCLK = 1'b0;
        wait_cyc(20);
        check("glitch_q7s", Q7S, 0);
        latch_chk(16'h0000, 1'b1, SLOW_H, "glitch");
`endif

        // Random frames against the model.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            int          n;
            logic [31:0] w;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : 16;
            w = $urandom;
            send_word(w, n, SLOW_H);
            latch_chk(m_sr, (m_cnt != 16), SLOW_H, $sformatf("rnd%0d_n%0d", f, n));
        end

        // Same-rate loopback: start-up latch then 256 frames of 0x1234; frame_cnt wraps.
        do_reset();
        latch_chk(16'h0000, 1'b1, FAST_H, "loop_first");
        for (int i = 0; i < 256; i++) begin
            send_word(32'h1234, 16, FAST_H);
            latch_chk(16'h1234, 1'b0, FAST_H, $sformatf("loop%0d", i));
            if (i == 254) check("fcnt_wrap0", frame_cnt, 0);
        end

        wait_cyc(10);
        check("vld_pulse_count", vld_seen, m_latches);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
